dcache_ctrl: RTL and testbench

Initiator-side controller for the direct-mapped dcache. It accepts load/store requests from the load-store unit, drives the dcache read/write ports, and inspects miss/ejection results. It refills missing lines from backing memory and writes ejected dirty lines back. Policy is write-allocate, write-back. It sits between the LSU and the dcache plus memory port.

---
 rtl/dcache_ctrl_pkg.sv | 31 +++
 rtl/dcache_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_ctrl_pkg.sv
// Shared types for the dcache controller: access sizes and controller FSM states.
package dcache_ctrl_pkg;

  typedef enum logic [1:0] {
    DC_SIZE_8  = 2'd0,
    DC_SIZE_16 = 2'd1,
    DC_SIZE_32 = 2'd2,
    DC_SIZE_64 = 2'd3
  } dcache_data_size_e;

  typedef enum logic [3:0] {
    INIT_RD,
    IDLE,
    LOOKUP,
    CHECK,
    STORE,
    RESP,
    MEM_RD,
    MEM_WAIT,
    FILL,
    EVICT_CHK,
    WB
  } dcache_ctrl_state_e;

  localparam int unsigned DCACHE_OFFSET_BITS = 3;

  function automatic int unsigned size_bytes(dcache_data_size_e s);
    return 32'd1 << s;
  endfunction

endpackage

// File: rtl/dcache_ctrl.sv
// Write-allocate, write-back controller between the LSU and a direct-mapped dcache.
// Sweeps every line in from memory after reset, then serves loads/stores with refill and victim write-back.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int addr_width      = 16,
  parameter int line_width      = 64,
  parameter int depth           = 64,
  parameter int line_addr_width = addr_width - 3
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic                       req_write_i,
  input  logic [addr_width-1:0]      req_addr_i,
  input  dcache_data_size_e          req_size_i,
  input  logic [63:0]                req_wdata_i,
  output logic                       resp_valid_o,
  output logic [63:0]                resp_rdata_o,
  output logic                       init_done_o,
  output logic [addr_width-1:0]      c_addr_o,
  output logic                       c_r_valid_o,
  output logic                       c_w_valid_o,
  output dcache_data_size_e          c_r_size_o,
  output dcache_data_size_e          c_w_size_o,
  output logic                       c_dirty_o,
  output logic [line_width-1:0]      c_write_o,
  input  logic                       c_r_valid_i,
  input  logic                       c_miss_i,
  input  logic                       c_ejected_valid_i,
  input  logic [line_width-1:0]      c_read_i,
  input  logic [line_width-1:0]      c_ejected_i,
  input  logic [line_addr_width-1:0] c_ejected_addr_i,
  output logic                       mem_req_valid_o,
  input  logic                       mem_req_ready_i,
  output logic                       mem_we_o,
  output logic [line_addr_width-1:0] mem_addr_o,
  output logic [line_width-1:0]      mem_wdata_o,
  input  logic                       mem_rvalid_i,
  input  logic [line_width-1:0]      mem_rdata_i
);

  localparam int idx_width = (depth > 1) ? $clog2(depth) : 1;

  if (line_width != 64) begin : g_line_width_check
    $error("dcache_ctrl: line_width must be 64");
  end

  dcache_ctrl_state_e state_q, state_d;

  logic [idx_width-1:0]       init_idx_q;
  logic                       init_done_q;
  logic                       lat_write_q;
  logic [addr_width-1:0]      lat_addr_q;
  dcache_data_size_e          lat_size_q;
  logic [63:0]                lat_wdata_q;
  logic [line_width-1:0]      line_buf_q;
  logic [line_addr_width-1:0] wb_addr_q;
  logic [63:0]                resp_rdata_q;

  logic [line_addr_width-1:0] fill_line;
  logic                       last_idx;

  // The sweep walks the init index; afterwards refills target the latched request line.
  assign fill_line = init_done_q ? lat_addr_q[addr_width-1:DCACHE_OFFSET_BITS]
                                 : line_addr_width'(init_idx_q);
  assign last_idx  = (init_idx_q == idx_width'(depth - 1));

  assign init_done_o  = init_done_q;
  assign resp_rdata_o = resp_rdata_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= INIT_RD;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      init_idx_q   <= '0;
      init_done_q  <= 1'b0;
      lat_write_q  <= 1'b0;
      lat_addr_q   <= '0;
      lat_size_q   <= DC_SIZE_8;
      lat_wdata_q  <= '0;
      line_buf_q   <= '0;
      wb_addr_q    <= '0;
      resp_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            lat_write_q <= req_write_i;
            lat_addr_q  <= req_addr_i;
            lat_size_q  <= req_size_i;
            lat_wdata_q <= req_wdata_i;
          end
        end
        CHECK: begin
          if (c_r_valid_i && !c_miss_i) begin
            resp_rdata_q <= lat_write_q ? 64'h0 : c_read_i[63:0];
          end
        end
        MEM_WAIT: begin
          if (mem_rvalid_i) begin
            line_buf_q <= mem_rdata_i;
          end
        end
        FILL: begin
          if (!init_done_q) begin
            if (last_idx) begin
              init_done_q <= 1'b1;
            end else begin
              init_idx_q <= init_idx_q + 1'b1;
            end
          end
        end
        // The fill data is no longer needed here, so the buffer is reused for the victim.
        EVICT_CHK: begin
          if (c_ejected_valid_i) begin
            wb_addr_q  <= c_ejected_addr_i;
            line_buf_q <= c_ejected_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d         = state_q;
    req_ready_o     = 1'b0;
    resp_valid_o    = 1'b0;
    c_addr_o        = '0;
    c_r_valid_o     = 1'b0;
    c_w_valid_o     = 1'b0;
    c_r_size_o      = DC_SIZE_8;
    c_w_size_o      = DC_SIZE_8;
    c_dirty_o       = 1'b0;
    c_write_o       = '0;
    mem_req_valid_o = 1'b0;
    mem_we_o        = 1'b0;
    mem_addr_o      = '0;
    mem_wdata_o     = '0;

    case (state_q)
      INIT_RD: state_d = MEM_RD;
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = LOOKUP;
      end
      LOOKUP: begin
        c_r_valid_o = 1'b1;
        c_addr_o    = lat_addr_q;
        c_r_size_o  = lat_size_q;
        state_d     = CHECK;
      end
      CHECK: begin
        if (c_r_valid_i) begin
          if (c_miss_i)         state_d = MEM_RD;
          else if (lat_write_q) state_d = STORE;
          else                  state_d = RESP;
        end
      end
      STORE: begin
        c_w_valid_o = 1'b1;
        c_dirty_o   = 1'b1;
        c_addr_o    = lat_addr_q;
        c_w_size_o  = lat_size_q;
        c_write_o   = line_width'(lat_wdata_q);
        state_d     = RESP;
      end
      RESP: begin
        resp_valid_o = 1'b1;
        state_d      = IDLE;
      end
      MEM_RD: begin
        mem_req_valid_o = 1'b1;
        mem_addr_o      = fill_line;
        if (mem_req_ready_i) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (mem_rvalid_i) state_d = FILL;
      end
      // A full-line read size makes any ejection carry the whole victim line.
      FILL: begin
        c_w_valid_o = 1'b1;
        c_addr_o    = {fill_line, {DCACHE_OFFSET_BITS{1'b0}}};
        c_w_size_o  = DC_SIZE_64;
        c_r_size_o  = DC_SIZE_64;
        c_write_o   = line_buf_q;
        if (init_done_q)   state_d = EVICT_CHK;
        else if (last_idx) state_d = IDLE;
        else               state_d = INIT_RD;
      end
      EVICT_CHK: begin
        state_d = c_ejected_valid_i ? WB : LOOKUP;
      end
      WB: begin
        mem_req_valid_o = 1'b1;
        mem_we_o        = 1'b1;
        mem_addr_o      = wb_addr_q;
        mem_wdata_o     = line_buf_q;
        if (mem_req_ready_i) state_d = LOOKUP;
      end
      default: state_d = INIT_RD;
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: behavioural dcache and line memory models, response scoreboard.
module tb_dcache_ctrl;
  import dcache_ctrl_pkg::*;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_write_i;
  logic [15:0]       req_addr_i;
  dcache_data_size_e req_size_i;
  logic [63:0]       req_wdata_i;
  logic              resp_valid_o;
  logic [63:0]       resp_rdata_o;
  logic              init_done_o;
  logic [15:0]       c_addr_o;
  logic              c_r_valid_o, c_w_valid_o;
  dcache_data_size_e c_r_size_o, c_w_size_o;
  logic              c_dirty_o;
  logic [63:0]       c_write_o;
  logic              c_r_valid_i, c_miss_i, c_ejected_valid_i;
  logic [63:0]       c_read_i, c_ejected_i;
  logic [12:0]       c_ejected_addr_i;
  logic              mem_req_valid_o;
  logic              mem_req_ready_i;
  logic              mem_we_o;
  logic [12:0]       mem_addr_o;
  logic [63:0]       mem_wdata_o;
  logic              mem_rvalid_i;
  logic [63:0]       mem_rdata_i;

  dcache_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_size_i(req_size_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .init_done_o(init_done_o),
    .c_addr_o(c_addr_o), .c_r_valid_o(c_r_valid_o), .c_w_valid_o(c_w_valid_o),
    .c_r_size_o(c_r_size_o), .c_w_size_o(c_w_size_o), .c_dirty_o(c_dirty_o),
    .c_write_o(c_write_o), .c_r_valid_i(c_r_valid_i), .c_miss_i(c_miss_i),
    .c_ejected_valid_i(c_ejected_valid_i), .c_read_i(c_read_i), .c_ejected_i(c_ejected_i),
    .c_ejected_addr_i(c_ejected_addr_i), .mem_req_valid_o(mem_req_valid_o),
    .mem_req_ready_i(mem_req_ready_i), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {logic [63:0] data; int cyc; bit timed;} exp_t;
  typedef struct {logic [63:0] data; int cyc;} resp_t;
  typedef struct {logic we; logic [12:0] addr; logic [63:0] data;} mem_ev_t;
  typedef struct {logic [12:0] addr; logic rdy;} stall_t;

  exp_t    exp_q[$];
  resp_t   resp_log[$];
  mem_ev_t ev_log[$];
  stall_t  stall_log[$];

  int cyc = 0;
  int checks = 0;
  int fails = 0;
  int stall_cycles = 0;
  int rd_lat = 1;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Behavioural dcache: 64 sets, 7-bit tags, contents survive reset.
  logic [63:0] cdata [64];
  logic [6:0]  ctag  [64];
  bit          cvalid[64];
  bit          cdirty[64];

  function automatic logic [63:0] size_mask(dcache_data_size_e s);
    int unsigned b = size_bytes(s);
    return (b == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'h1 << (8 * b)) - 64'h1);
  endfunction

  function automatic logic [63:0] rd_extract(logic [63:0] line, logic [2:0] off, dcache_data_size_e s);
    return (line >> (8 * off)) & size_mask(s);
  endfunction

  function automatic logic [63:0] wr_merge(logic [63:0] old, logic [63:0] wd, logic [2:0] off, dcache_data_size_e s);
    logic [63:0] m = size_mask(s) << (8 * off);
    return (old & ~m) | ((wd << (8 * off)) & m);
  endfunction

  function automatic bit is_hit(logic [15:0] a);
    return cvalid[a[8:3]] && (ctag[a[8:3]] == a[15:9]);
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      c_r_valid_i       <= 1'b0;
      c_miss_i          <= 1'b0;
      c_read_i          <= '0;
      c_ejected_valid_i <= 1'b0;
      c_ejected_i       <= '0;
      c_ejected_addr_i  <= '0;
    end else begin
      c_r_valid_i       <= c_r_valid_o;
      c_ejected_valid_i <= 1'b0;
      if (c_r_valid_o) begin
        c_miss_i <= !is_hit(c_addr_o);
        c_read_i <= is_hit(c_addr_o) ? rd_extract(cdata[c_addr_o[8:3]], c_addr_o[2:0], c_r_size_o) : 64'h0;
      end
      if (c_w_valid_o) begin
        if (!is_hit(c_addr_o) && cvalid[c_addr_o[8:3]] && cdirty[c_addr_o[8:3]]) begin
          c_ejected_valid_i <= 1'b1;
          c_ejected_addr_i  <= {ctag[c_addr_o[8:3]], c_addr_o[8:3]};
          c_ejected_i       <= cdata[c_addr_o[8:3]];
        end
        cdata[c_addr_o[8:3]]  <= wr_merge(is_hit(c_addr_o) ? cdata[c_addr_o[8:3]] : 64'h0,
                                          c_write_o, c_addr_o[2:0], c_w_size_o);
        ctag[c_addr_o[8:3]]   <= c_addr_o[15:9];
        cvalid[c_addr_o[8:3]] <= 1'b1;
        cdirty[c_addr_o[8:3]] <= c_dirty_o;
      end
    end
  end

  // Line memory: line i holds i*0x0101..01 except line 0x45; written lines override.
  logic [63:0] mem_wr  [8192];
  bit          mem_wr_v[8192];
  bit          rd_pending;
  int          rd_wait;
  int          stall_cnt;
  logic [12:0] rd_addr;

  function automatic logic [63:0] mem_read(logic [12:0] a);
    if (mem_wr_v[a]) return mem_wr[a];
    if (a == 13'h45) return 64'h1234;
    return 64'(a) * 64'h0101_0101_0101_0101;
  endfunction

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      mem_req_ready_i <= 1'b0;
      mem_rvalid_i    <= 1'b0;
      mem_rdata_i     <= '0;
      rd_pending      <= 1'b0;
      rd_wait         <= 0;
      stall_cnt       <= 0;
      rd_addr         <= '0;
    end else begin
      mem_rvalid_i <= 1'b0;
      if (rd_pending && rd_wait == 0) begin
        mem_rvalid_i <= 1'b1;
        mem_rdata_i  <= mem_read(rd_addr);
        rd_pending   <= 1'b0;
      end else if (rd_pending) begin
        rd_wait <= rd_wait - 1;
      end
      if (mem_req_valid_o && stall_cnt < stall_cycles) begin
        mem_req_ready_i <= 1'b0;
        stall_cnt       <= stall_cnt + 1;
        stall_log.push_back('{mem_addr_o, req_ready_o});
      end else begin
        mem_req_ready_i <= 1'b1;
        if (mem_req_valid_o) begin
          ev_log.push_back('{mem_we_o, mem_addr_o, mem_wdata_o});
          stall_cnt <= 0;
          if (mem_we_o) begin
            mem_wr[mem_addr_o]   <= mem_wdata_o;
            mem_wr_v[mem_addr_o] <= 1'b1;
          end else begin
            rd_pending <= 1'b1;
            rd_addr    <= mem_addr_o;
            rd_wait    <= rd_lat;
          end
        end
      end
    end
  end

  always @(negedge clk_i) begin
    if (resp_valid_o) resp_log.push_back('{resp_rdata_o, cyc});
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctrl"}, 64'({req_ready_o, resp_valid_o, init_done_o, mem_req_valid_o,
                                     mem_we_o, c_r_valid_o, c_w_valid_o, c_dirty_o}), 64'h0);
    checkOutput({tag, "_sizes"}, 64'({c_r_size_o, c_w_size_o}), 64'h0);
    checkOutput({tag, "_addrs"}, 64'({c_addr_o, mem_addr_o}), 64'h0);
    checkOutput({tag, "_data"}, resp_rdata_o | c_write_o | mem_wdata_o, 64'h0);
  endtask

  task automatic waitInit(input string tag);
    int n_rd = 0;
    int n_wr = 0;
    int order_err = 0;
    for (int i = 0; i < 2000 && !init_done_o; i++) tick();
    checkOutput({tag, "_init_done"}, 64'(init_done_o), 64'h1);
    foreach (ev_log[i]) begin
      if (ev_log[i].we) n_wr++;
      else begin
        if (ev_log[i].addr != 13'(n_rd)) order_err++;
        n_rd++;
      end
    end
    checkOutput({tag, "_reads"}, 64'(n_rd), 64'd64);
    checkOutput({tag, "_writes"}, 64'(n_wr), 64'd0);
    checkOutput({tag, "_order"}, 64'(order_err), 64'd0);
    checkOutput({tag, "_first_rd"}, 64'(ev_log.size() != 0 ? ev_log[0].addr : 13'h1FFF), 64'h0);
  endtask

  task automatic applyStimulus(input bit wr, input logic [15:0] addr, input dcache_data_size_e size,
                               input logic [63:0] wdata, input logic [63:0] exp_data, input int exp_lat);
    for (int i = 0; i < 200 && !req_ready_o; i++) tick();
    if (!req_ready_o) begin
      checkOutput("req_ready_wait", 64'(req_ready_o), 64'h1);
      return;
    end
    req_valid_i = 1'b1;
    req_write_i = wr;
    req_addr_i  = addr;
    req_size_i  = size;
    req_wdata_i = wdata;
    exp_q.push_back('{exp_data, cyc + exp_lat, exp_lat >= 0});
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic checkResp(input string tag);
    resp_t r;
    exp_t  e;
    for (int i = 0; i < 500 && resp_log.size() == 0; i++) tick();
    checkOutput({tag, "_resp_seen"}, 64'(resp_log.size() != 0), 64'h1);
    if (resp_log.size() != 0 && exp_q.size() != 0) begin
      r = resp_log.pop_front();
      e = exp_q.pop_front();
      checkOutput({tag, "_rdata"}, r.data, e.data);
      if (e.timed) checkOutput({tag, "_cycle"}, 64'(r.cyc), 64'(e.cyc));
    end else if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int bad_addr;
    int bad_rdy;
    rst_ni      = 1'b0;
    req_valid_i = 1'b0;
    req_write_i = 1'b0;
    req_addr_i  = '0;
    req_size_i  = DC_SIZE_8;
    req_wdata_i = '0;
    repeat (2) tick();
    checkAllZero("reset");

    // Initial sweep
    ev_log.delete();
    rst_ni = 1'b1;
    waitInit("sweep1");
    tick();
    checkOutput("ready_after_init", 64'(req_ready_o), 64'h1);

    // Load hits, full line and 32-bit upper half
    ev_log.delete();
    applyStimulus(1'b0, 16'h0028, DC_SIZE_64, 64'h0, 64'h0505_0505_0505_0505, 3);
    checkResp("load_hit");
    applyStimulus(1'b0, 16'h002C, DC_SIZE_32, 64'h0, 64'h0000_0000_0505_0505, 3);
    checkResp("load_hit32");

    // Store hit and readback
    applyStimulus(1'b1, 16'h0028, DC_SIZE_64, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 4);
    checkResp("store_hit");
    applyStimulus(1'b0, 16'h0028, DC_SIZE_64, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 3);
    checkResp("store_readback");
    checkOutput("hit_mem_traffic", 64'(ev_log.size()), 64'd0);

    // Dirty miss: refill read precedes victim write-back
    ev_log.delete();
    applyStimulus(1'b0, 16'h0228, DC_SIZE_64, 64'h0, 64'h1234, -1);
    checkResp("dirty_miss");
    checkOutput("dirty_miss_events", 64'(ev_log.size()), 64'd2);
    if (ev_log.size() == 2) begin
      checkOutput("dirty_miss_rd", 64'({ev_log[0].we, ev_log[0].addr}), 64'h0045);
      checkOutput("dirty_miss_wb", 64'({ev_log[1].we, ev_log[1].addr}), 64'h2005);
      checkOutput("dirty_miss_wb_data", ev_log[1].data, 64'hDEAD_BEEF_CAFE_F00D);
    end

    // Clean miss with memory back-pressure
    ev_log.delete();
    stall_log.delete();
    stall_cycles = 5;
    applyStimulus(1'b0, 16'h0230, DC_SIZE_64, 64'h0, 64'h4646_4646_4646_4646, -1);
    checkResp("clean_miss");
    stall_cycles = 0;
    bad_addr = 0;
    bad_rdy  = 0;
    foreach (stall_log[i]) begin
      if (stall_log[i].addr != 13'h46) bad_addr++;
      if (stall_log[i].rdy) bad_rdy++;
    end
    checkOutput("stall_cycles", 64'(stall_log.size()), 64'd5);
    checkOutput("stall_addr_stable", 64'(bad_addr), 64'd0);
    checkOutput("stall_req_ready_low", 64'(bad_rdy), 64'd0);
    checkOutput("clean_miss_events", 64'(ev_log.size()), 64'd1);
    checkOutput("clean_miss_rd", 64'(ev_log.size() != 0 ? {ev_log[0].we, ev_log[0].addr} : 14'h3FFF), 64'h0046);

    // Reset while waiting for refill data on a dirty miss
    applyStimulus(1'b1, 16'h0228, DC_SIZE_64, 64'hA5A5_A5A5_A5A5_A5A5, 64'h0, 4);
    checkResp("store_before_reset");
    ev_log.delete();
    rd_lat = 3;
    applyStimulus(1'b0, 16'h0428, DC_SIZE_64, 64'h0, 64'h0, -1);
    for (int i = 0; i < 50 && ev_log.size() == 0; i++) tick();
    checkOutput("abort_rd_addr", 64'(ev_log.size() != 0 ? ev_log[0].addr : 13'h1FFF), 64'h85);
    tick();
    checkOutput("abort_in_wait", 64'({mem_req_valid_o, resp_valid_o}), 64'h0);
    rst_ni = 1'b0;
    #1;
    checkAllZero("mid_reset");
    exp_q.delete();
    repeat (3) tick();
    ev_log.delete();
    rd_lat = 1;
    rst_ni = 1'b1;
    waitInit("sweep2");
    checkOutput("no_resp_across_reset", 64'(resp_log.size()), 64'd0);

    // Written-back line survives; the dirty line lost to reset does not
    applyStimulus(1'b0, 16'h0028, DC_SIZE_64, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 3);
    checkResp("after_reset_hit");
    applyStimulus(1'b0, 16'h0228, DC_SIZE_64, 64'h0, 64'h1234, -1);
    checkResp("after_reset_miss");
    repeat (3) tick();
    checkOutput("no_extra_resp", 64'(resp_log.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
